timestamp_word_decoder: RTL
===========================

// Module: timestamp_word_decoder
// PURPOSE
//  Readout-side decoder for the timestamp word stream. Pops 32-bit words from a show-ahead FIFO
//  and pairs low/high words tagged with IDENTIFIER. Emits 48-bit timestamps on a valid/ready port.
//  Counts protocol errors and foreign words. Sits between the FIFO arbiter output and trigger-matching logic.
// PARAMETERS
//  IDENTIFIER  7'b0000001  source ID expected in word bits [31:25]
//  CNT_W       8           width of saturating error/foreign counters
// PORTS
//  CLK          in   1      single clock; all logic on posedge
//  RST_N        in   1      asynchronous active-low reset
//  ENABLE       in   1      1: consume stream; 0: FIFO_READ held 0, state frozen
//  FIFO_EMPTY   in   1      source FIFO empty
//  FIFO_DATA    in   32     show-ahead word, valid while FIFO_EMPTY=0
//  FIFO_READ    out  1      pop strobe (combinational)
//  TS_VALID     out  1      TS_DATA holds a complete timestamp
//  TS_READY     in   1      consumer accepts TS_DATA when TS_VALID&TS_READY
//  TS_DATA      out  48     {high[23:0], low[23:0]}
//  TS_DELTA     out  48     TS_DATA minus previous emitted TS (TIMESTAMP_DECODER_DELTA_EN only)
//  ORPHAN_CNT   out  CNT_W  high words with no pending low word
//  OVERWR_CNT   out  CNT_W  low words that replaced a pending low word
//  FOREIGN_CNT  out  CNT_W  words whose [31:25] != IDENTIFIER
//  CLR_CNT      in   1      synchronous clear of all three counters
// BEHAVIOUR
//  Word format: [31:25]=ID, [24]=0 low (ts[23:0]), [24]=1 high (ts[47:24]).
//  Reset: state=IDLE, TS_VALID=0, TS_DATA=0, TS_DELTA=0, counters=0, low_buf=0, prev_ts=0.
//  Pop: FIFO_READ = ENABLE & ~FIFO_EMPTY & (~TS_VALID | TS_READY). A word is consumed only in a cycle with FIFO_READ=1.
//  Sustained rate: one word per cycle while the output port is not stalled.
//  FSM states: IDLE (no low pending), LOW (low_buf valid).
//   IDLE + low  -> low_buf<=data[23:0], LOW
//   IDLE + high -> ORPHAN_CNT++, stay IDLE
//   LOW  + low  -> OVERWR_CNT++, low_buf replaced, stay LOW
//   LOW  + high -> TS_DATA<={data[23:0],low_buf}, TS_VALID<=1 next cycle, IDLE
//   any  + foreign ID -> FOREIGN_CNT++, state unchanged
//  Latency: high word popped in cycle N -> TS_VALID=1 in cycle N+1.
//  TS_VALID clears on TS_VALID&TS_READY unless a new TS completes the same cycle; then it stays 1 with the new data.
//  Simultaneous accept and complete is lossless (back-to-back rate).
//  Stall: TS_VALID&~TS_READY holds TS_DATA/TS_DELTA stable and FIFO_READ=0.
//  Counters saturate at 2^CNT_W-1. CLR_CNT has priority over increment in the same cycle.
//  ENABLE=0 mid-pair keeps low_buf/state; pairing resumes when ENABLE returns.
//  Async reset mid-pair discards low_buf and any pending TS.
// CONFIGURATION
//  TIMESTAMP_DECODER_DELTA_EN defined:
//   TS_DELTA = new_ts - prev_ts, computed modulo 2^48 (wrap gives the correct small delta).
//   prev_ts updates when a TS is loaded into the output register. First TS after reset gives delta = ts - 0.
//  TIMESTAMP_DECODER_DELTA_EN undefined: no subtractor and no prev_ts register; TS_DELTA tied to 0.
// STRUCTURE
//  Package timestamp_pkg holds shared definitions:
//   TS_W=48, HALF_W=24, ID_LSB=25, FLAG_BIT=24, state enum {IDLE, LOW}
//   helper function make_ts_word(id, hi, data) for benches
//  Sub-module sat_counter #(W), instantiated three times: inc, clr, saturating count.
// TESTING
//  1 0x02ABCDEF then 0x03123456, TS_READY=1 -> one TS_VALID pulse, TS_DATA=48'h123456ABCDEF, counters 0.
//  2 0x03000001 in IDLE -> ORPHAN_CNT=1, no TS_VALID.
//    Then 0x02000010, 0x02000020, 0x03000000 -> OVERWR_CNT=1, TS_DATA=48'h000000000020.
//  3 0x7E000000 between a low and a high word -> FOREIGN_CNT=1; pair still decodes correctly.
//  4 TS_READY=0 for 10 cycles with 4 pairs queued -> FIFO_READ=0 while stalled, TS_DATA stable.
//    Release -> 4 TS in order, no loss, back-to-back.
//  5 DELTA_EN: TS 48'hFFFFFFFFFFFE then 48'h000000000003 -> TS_DELTA=48'h5; macro off -> TS_DELTA=0.
//  6 RST_N low after a low word, release, send high 0x03000001 -> ORPHAN_CNT=1, TS_VALID stays 0.
//    255 orphans + 5 more -> ORPHAN_CNT=255. CLR_CNT with an orphan in the same cycle -> 0.

Source files
------------

// File: rtl/timestamp_pkg.sv
// Package: timestamp_pkg
// Shared definitions for the timestamp word decoder: word field positions,
// timestamp widths, the pairing FSM state type and a word-builder helper.
// Optional feature macro used by the decoder: TIMESTAMP_DECODER_DELTA_EN.
package timestamp_pkg;

    localparam int TS_W     = 48;
    localparam int HALF_W   = 24;
    localparam int ID_LSB   = 25;
    localparam int FLAG_BIT = 24;

    // IDLE: no low word pending; LOW: low_buf holds the low half of a timestamp.
    typedef enum logic {
        IDLE = 1'b0,
        LOW  = 1'b1
    } state_t;

    // Builds a stream word {id, hi_flag, data[23:0]}.
    function automatic logic [31:0] make_ts_word(input logic [6:0] id,
                                                 input logic hi,
                                                 input logic [HALF_W-1:0] data);
        return {id, hi, data};
    endfunction

endpackage

// File: rtl/timestamp_word_decoder_sat_counter.sv
// Module: sat_counter
// Saturating up-counter with synchronous clear.
// Ports:
//   clk    in   1  clock
//   rst_n  in   1  asynchronous active-low reset
//   inc    in   1  increment request (ignored once the count is all ones)
//   clr    in   1  synchronous clear, wins over inc
//   cnt    out  W  current count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/timestamp_word_decoder.sv
// Module: timestamp_word_decoder
// Pops 32-bit words from a show-ahead FIFO, pairs low/high halves tagged with
// IDENTIFIER and presents 48-bit timestamps on a valid/ready output port.
// Counts orphan high words, overwritten low words and foreign-ID words.
// Optional macro TIMESTAMP_DECODER_DELTA_EN adds TS_DELTA = TS - previous TS
// (modulo 2^48); when undefined TS_DELTA is tied to zero.
// Ports:
//   CLK, RST_N            clock, asynchronous active-low reset
//   ENABLE                1 consumes the stream, 0 freezes everything
//   FIFO_EMPTY/FIFO_DATA  show-ahead FIFO head; FIFO_READ pops it (combinational)
//   TS_VALID/TS_READY     output handshake; TS_DATA {high, low}, TS_DELTA
//   ORPHAN_CNT, OVERWR_CNT, FOREIGN_CNT  saturating counters, CLR_CNT clears
//   dbg_state             current pairing state
//
// Handshake: TS_DATA/TS_DELTA are transferred on a cycle where
// TS_VALID & TS_READY; while TS_VALID & ~TS_READY they are held stable and no
// word is popped, so a completing high word can never overwrite an unaccepted
// timestamp. An accept and a new completion in the same cycle keep TS_VALID
// high with the new data.
module timestamp_word_decoder
    import timestamp_pkg::*;
#(
    parameter logic [6:0] IDENTIFIER = 7'b0000001,
    parameter int         CNT_W      = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             ENABLE,
    input  logic             FIFO_EMPTY,
    input  logic [31:0]      FIFO_DATA,
    output logic             FIFO_READ,
    output logic             TS_VALID,
    input  logic             TS_READY,
    output logic [TS_W-1:0]  TS_DATA,
    output logic [TS_W-1:0]  TS_DELTA,
    output logic [CNT_W-1:0] ORPHAN_CNT,
    output logic [CNT_W-1:0] OVERWR_CNT,
    output logic [CNT_W-1:0] FOREIGN_CNT,
    input  logic             CLR_CNT,
    output state_t           dbg_state
);

    state_t            state_q, state_d;
    logic [HALF_W-1:0] low_buf_q, low_buf_d;
    logic              ts_valid_q, ts_valid_d;
    logic [TS_W-1:0]   ts_data_q, ts_data_d;

    logic              fifo_read;
    logic              word_ours;
    logic              word_high;
    logic              word_foreign;
    logic              low_load;
    logic              inc_orphan;
    logic              inc_overwr;
    logic              ts_complete;
    logic [TS_W-1:0]   new_ts;

    assign fifo_read    = ENABLE & ~FIFO_EMPTY & (~ts_valid_q | TS_READY);
    assign word_high    = FIFO_DATA[FLAG_BIT];
    assign word_ours    = fifo_read & (FIFO_DATA[31:ID_LSB] == IDENTIFIER);
    assign word_foreign = fifo_read & (FIFO_DATA[31:ID_LSB] != IDENTIFIER);
    assign new_ts       = {FIFO_DATA[HALF_W-1:0], low_buf_q};

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; foreign words never move the FSM.
    always_comb begin
        state_d = state_q;
        if (word_ours) begin
            case (state_q)
                IDLE:    state_d = word_high ? IDLE : LOW;
                LOW:     state_d = word_high ? IDLE : LOW;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output/event decode for the consumed word.
    always_comb begin
        low_load    = 1'b0;
        inc_orphan  = 1'b0;
        inc_overwr  = 1'b0;
        ts_complete = 1'b0;
        if (word_ours) begin
            case (state_q)
                IDLE: begin
                    low_load   = ~word_high;
                    inc_orphan = word_high;
                end
                LOW: begin
                    low_load    = ~word_high;
                    inc_overwr  = ~word_high;
                    ts_complete = word_high;
                end
                default: ;
            endcase
        end
    end

    // Datapath next values.
    always_comb begin
        low_buf_d  = low_load ? FIFO_DATA[HALF_W-1:0] : low_buf_q;
        ts_data_d  = ts_complete ? new_ts : ts_data_q;
        ts_valid_d = ts_valid_q;
        if (ts_complete) begin
            ts_valid_d = 1'b1;
        end else if (ts_valid_q && TS_READY) begin
            ts_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            low_buf_q  <= '0;
            ts_valid_q <= 1'b0;
            ts_data_q  <= '0;
        end else begin
            low_buf_q  <= low_buf_d;
            ts_valid_q <= ts_valid_d;
            ts_data_q  <= ts_data_d;
        end
    end

`ifdef TIMESTAMP_DECODER_DELTA_EN
    logic [TS_W-1:0] prev_ts_q, prev_ts_d;
    logic [TS_W-1:0] ts_delta_q, ts_delta_d;

    // Modulo-2^48 subtraction, so a wrap of the timestamp still yields the small delta.
    always_comb begin
        prev_ts_d  = ts_complete ? new_ts : prev_ts_q;
        ts_delta_d = ts_complete ? (new_ts - prev_ts_q) : ts_delta_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            prev_ts_q  <= '0;
            ts_delta_q <= '0;
        end else begin
            prev_ts_q  <= prev_ts_d;
            ts_delta_q <= ts_delta_d;
        end
    end

    assign TS_DELTA = ts_delta_q;
`else
    assign TS_DELTA = '0;
`endif

    sat_counter #(.W(CNT_W)) u_orphan_cnt (
        .clk(CLK), .rst_n(RST_N), .inc(inc_orphan), .clr(CLR_CNT), .cnt(ORPHAN_CNT)
    );

    sat_counter #(.W(CNT_W)) u_overwr_cnt (
        .clk(CLK), .rst_n(RST_N), .inc(inc_overwr), .clr(CLR_CNT), .cnt(OVERWR_CNT)
    );

    sat_counter #(.W(CNT_W)) u_foreign_cnt (
        .clk(CLK), .rst_n(RST_N), .inc(word_foreign), .clr(CLR_CNT), .cnt(FOREIGN_CNT)
    );

    assign FIFO_READ = fifo_read;
    assign TS_VALID  = ts_valid_q;
    assign TS_DATA   = ts_data_q;
    assign dbg_state = state_q;

endmodule
